// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges hazard-unit stall/flush requests with data-memory wait and the
// multi-cycle mult/div handshake. It also runs a wait-state watchdog and
// keeps saturating stall/flush performance counters.
module pipeline_stall_sequencer #(
  parameter int WDOG_LIMIT = 255,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_use,
  input  logic                 branch_taken,
  input  logic                 muldiv_req,
  input  logic                 muldiv_done,
  input  logic                 mem_wait,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_write,
  output logic                 id_ex_flush,
  output logic                 ex_mem_write,
  output logic                 ex_mem_flush,
  output logic                 mem_wb_flush,
  output logic                 muldiv_start,
  output logic [1:0]           state,
  output logic                 wdog_err,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  // The watchdog only has to count up to WDOG_LIMIT-1.
  localparam int WDOG_W = (WDOG_LIMIT > 2) ? $clog2(WDOG_LIMIT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } seqState_t;

  seqState_t         curState;
  seqState_t         nextState;
  logic [WDOG_W-1:0] wdog;
  logic              doneSeen;

  // Decoded actions for this cycle.
  logic useRun;
  logic doFreeze;
  logic doLoadUse;
  logic doBranch;
  logic doStart;
  logic doMdHold;
  logic stillWaiting;
  logic wdogInc;
  logic wdogClr;
  logic setDone;
  logic clrDone;

  assign state = curState;

  // Decode state and inputs into control enables and next-state actions.
  always_comb begin
    // NOTE: every signal gets a default up front. No path can leave one unassigned, so no latch is inferred.
    nextState    = curState;
    useRun       = 1'b0;
    doFreeze     = 1'b0;
    doLoadUse    = 1'b0;
    doBranch     = 1'b0;
    doStart      = 1'b0;
    doMdHold     = 1'b0;
    stillWaiting = 1'b0;
    wdogInc      = 1'b0;
    wdogClr      = 1'b0;
    setDone      = 1'b0;
    clrDone      = 1'b0;

    case (curState)
      MEM_WAIT: begin
        if (mem_wait) begin
          doFreeze     = 1'b1;
          stillWaiting = 1'b1;
          wdogInc      = 1'b1;
        end else begin
          useRun  = 1'b1;
          wdogClr = 1'b1;
        end
      end
      MD_WAIT: begin
        if (mem_wait) begin
          doFreeze     = 1'b1;
          stillWaiting = 1'b1;
          wdogInc      = 1'b1;
          setDone      = muldiv_done;
        end else if (muldiv_done || doneSeen) begin
          // Result available: let the whole pipe advance this cycle.
          clrDone   = 1'b1;
          wdogClr   = 1'b1;
          nextState = RUN;
        end else begin
          doMdHold     = 1'b1;
          stillWaiting = 1'b1;
          wdogInc      = 1'b1;
        end
      end
      default: useRun = 1'b1;  // RUN, and the unused encoding 3
    endcase

    // Priority: mem_wait > load_use > branch_taken > muldiv_req.
    // A branch seen together with load_use is dropped. Its operand is stale,
    // and the hazard logic presents the branch again.
    if (useRun) begin
      nextState = RUN;
      if (mem_wait) begin
        doFreeze  = 1'b1;
        nextState = MEM_WAIT;
      end else if (load_use) begin
        doLoadUse = 1'b1;
      end else if (branch_taken) begin
        doBranch = 1'b1;
      end else if (muldiv_req) begin
        doStart   = 1'b1;
        doMdHold  = 1'b1;
        nextState = MD_WAIT;
      end
    end

    pc_write     = !(doFreeze || doLoadUse || doMdHold);
    if_id_write  = !(doFreeze || doLoadUse || doMdHold);
    id_ex_write  = !(doFreeze || doMdHold);
    ex_mem_write = !doFreeze;
    if_id_flush  = doBranch;
    id_ex_flush  = doLoadUse;
    ex_mem_flush = doMdHold;
    mem_wb_flush = doFreeze;
    muldiv_start = doStart;

    // Hold every enable low while reset is asserted.
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      muldiv_start = 1'b0;
    end
  end

  // Update the FSM, watchdog, done latch and saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values.
    if (reset) begin
      curState  <= RUN;
      wdog      <= '0;
      doneSeen  <= 1'b0;
      wdog_err  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stillWaiting && wdog == WDOG_LAST) begin
        // Too long in a wait state: abort back to RUN and raise the sticky flag.
        wdog_err <= 1'b1;
        curState <= RUN;
        wdog     <= '0;
        doneSeen <= 1'b0;
      end else begin
        curState <= nextState;
        if (wdogClr)      wdog <= '0;
        else if (wdogInc) wdog <= wdog + WDOG_W'(1);
        if (clrDone)      doneSeen <= 1'b0;
        else if (setDone) doneSeen <= 1'b1;
      end

      if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer.
// Instance A uses the default parameters. Instance B uses WDOG_LIMIT=4 and
// CNT_WIDTH=4 for the watchdog and saturation cases. Both instances share
// the same inputs.
module tb_pipeline_stall_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic loadUse, branchTaken, muldivReq, muldivDone, memWait;

  // Control vector bit order: pc, ifIdW, ifIdF, idExW, idExF, exMemW, exMemF, memWbF, start.
  localparam logic [8:0] C_DEF = 9'b110101000;
  localparam logic [8:0] C_BR  = 9'b111101000;
  localparam logic [8:0] C_LU  = 9'b000111000;
  localparam logic [8:0] C_FRZ = 9'b000000010;
  localparam logic [8:0] C_MDS = 9'b000001101;
  localparam logic [8:0] C_MDW = 9'b000001100;
  localparam logic [8:0] C_RST = 9'b000000000;

  // Input vector bit order: loadUse, branchTaken, muldivReq, muldivDone, memWait.
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_LU   = 5'b10000;
  localparam logic [4:0] I_BR   = 5'b01000;
  localparam logic [4:0] I_LUBR = 5'b11000;
  localparam logic [4:0] I_MREQ = 5'b00100;
  localparam logic [4:0] I_MDON = 5'b00110;
  localparam logic [4:0] I_MW   = 5'b00001;
  localparam logic [4:0] I_MWLU = 5'b10001;
  localparam logic [4:0] I_MWMQ = 5'b00101;
  localparam logic [4:0] I_MWMD = 5'b00111;

  logic aPc, aIfIdW, aIfIdF, aIdExW, aIdExF, aExMemW, aExMemF, aMemWbF, aStart, aWdogErr;
  logic [1:0]  aState;
  logic [31:0] aStallCnt, aFlushCnt;
  logic bPc, bIfIdW, bIfIdF, bIdExW, bIdExF, bExMemW, bExMemF, bMemWbF, bStart, bWdogErr;
  logic [1:0]  bState;
  logic [3:0]  bStallCnt, bFlushCnt;
  logic [8:0]  aCtl;

  assign aCtl = {aPc, aIfIdW, aIfIdF, aIdExW, aIdExF, aExMemW, aExMemF, aMemWbF, aStart};

  pipeline_stall_sequencer dutA (
    .clk(clk), .reset(reset), .load_use(loadUse), .branch_taken(branchTaken),
    .muldiv_req(muldivReq), .muldiv_done(muldivDone), .mem_wait(memWait),
    .pc_write(aPc), .if_id_write(aIfIdW), .if_id_flush(aIfIdF), .id_ex_write(aIdExW),
    .id_ex_flush(aIdExF), .ex_mem_write(aExMemW), .ex_mem_flush(aExMemF),
    .mem_wb_flush(aMemWbF), .muldiv_start(aStart), .state(aState), .wdog_err(aWdogErr),
    .stall_cnt(aStallCnt), .flush_cnt(aFlushCnt)
  );

  pipeline_stall_sequencer #(.WDOG_LIMIT(4), .CNT_WIDTH(4)) dutB (
    .clk(clk), .reset(reset), .load_use(loadUse), .branch_taken(branchTaken),
    .muldiv_req(muldivReq), .muldiv_done(muldivDone), .mem_wait(memWait),
    .pc_write(bPc), .if_id_write(bIfIdW), .if_id_flush(bIfIdF), .id_ex_write(bIdExW),
    .id_ex_flush(bIdExF), .ex_mem_write(bExMemW), .ex_mem_flush(bExMemF),
    .mem_wb_flush(bMemWbF), .muldiv_start(bStart), .state(bState), .wdog_err(bWdogErr),
    .stall_cnt(bStallCnt), .flush_cnt(bFlushCnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] in;
    logic [8:0] ctl;
    logic [1:0] stAfter;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs shortly after a rising edge and let the combinational outputs settle.
  task automatic setIn(input logic [4:0] v);
    {loadUse, branchTaken, muldivReq, muldivDone, memWait} = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    setIn(I_NONE);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    setIn(I_NONE);

    // Reset state.
    tick();
    check("rst_ctl", 32'(aCtl), 32'(C_RST));
    check("rst_state", 32'(aState), 32'd0);
    check("rst_cnt", aStallCnt | aFlushCnt, 32'd0);
    check("rst_wdog_err", 32'(aWdogErr), 32'd0);
    reset = 1'b0;

    // load_use wins over a branch taken in the same cycle.
    setIn(I_LUBR);
    check("lu_br_ctl", 32'(aCtl), 32'(C_LU));
    tick();
    check("lu_br_stall", aStallCnt, 32'd1);
    check("lu_br_flush", aFlushCnt, 32'd0);

    // Table-driven single-cycle rules, applied from RUN.
    tbl[0]  = '{I_NONE, C_DEF, 2'd0};
    tbl[1]  = '{I_BR,   C_BR,  2'd0};
    tbl[2]  = '{I_LU,   C_LU,  2'd0};
    tbl[3]  = '{I_LUBR, C_LU,  2'd0};
    tbl[4]  = '{I_MWLU, C_FRZ, 2'd1};
    tbl[5]  = '{I_MW,   C_FRZ, 2'd1};
    tbl[6]  = '{I_BR,   C_BR,  2'd0};
    tbl[7]  = '{I_MW,   C_FRZ, 2'd1};
    tbl[8]  = '{I_MREQ, C_MDS, 2'd2};
    tbl[9]  = '{I_MREQ, C_MDW, 2'd2};
    tbl[10] = '{I_MDON, C_DEF, 2'd0};
    tbl[11] = '{I_NONE, C_DEF, 2'd0};
    doReset();
    for (int i = 0; i < 12; i++) begin
      setIn(tbl[i].in);
      check($sformatf("tbl%0d_ctl", i), 32'(aCtl), 32'(tbl[i].ctl));
      tick();
      check($sformatf("tbl%0d_state", i), 32'(aState), 32'(tbl[i].stAfter));
    end
    check("tbl_stall", aStallCnt, 32'd7);
    check("tbl_flush", aFlushCnt, 32'd2);

    // mult/div request at t, done at t+5.
    doReset();
    setIn(I_MREQ);
    check("md_t0", 32'(aCtl), 32'(C_MDS));
    tick();
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("md_t%0d", k), 32'(aCtl), 32'(C_MDW));
      tick();
    end
    setIn(I_MDON);
    check("md_t5", 32'(aCtl), 32'(C_DEF));
    tick();
    setIn(I_NONE);
    check("md_t6_state", 32'(aState), 32'd0);
    check("md_stall", aStallCnt, 32'd5);

    // Done arrives during a memory wait and is released after the wait ends.
    doReset();
    setIn(I_MREQ);
    check("mdm_t0", 32'(aCtl), 32'(C_MDS));
    tick();
    setIn(I_MREQ);
    check("mdm_t1", 32'(aCtl), 32'(C_MDW));
    tick();
    setIn(I_MWMQ);
    check("mdm_t2", 32'(aCtl), 32'(C_FRZ));
    tick();
    setIn(I_MWMD);
    check("mdm_t3", 32'(aCtl), 32'(C_FRZ));
    tick();
    setIn(I_MWMQ);
    check("mdm_t4", 32'(aCtl), 32'(C_FRZ));
    tick();
    check("mdm_t4_state", 32'(aState), 32'd2);
    setIn(I_MREQ);
    check("mdm_t5_release", 32'(aCtl), 32'(C_DEF));
    tick();
    setIn(I_NONE);
    check("mdm_t6_state", 32'(aState), 32'd0);

    // Watchdog on instance B, with mem_wait held high from t.
    doReset();
    setIn(I_MW);
    tick();
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("wd_state_t%0d", k), 32'(bState), 32'd1);
      check($sformatf("wd_err_t%0d", k), 32'(bWdogErr), 32'd0);
      tick();
    end
    check("wd_state_t4", 32'(bState), 32'd1);
    tick();
    check("wd_abort_state", 32'(bState), 32'd0);
    check("wd_abort_err", 32'(bWdogErr), 32'd1);
    setIn(I_NONE);
    tick();
    tick();
    check("wd_err_sticky", 32'(bWdogErr), 32'd1);

    // stall_cnt saturates on instance B.
    doReset();
    check("sat_err_cleared", 32'(bWdogErr), 32'd0);
    setIn(I_LU);
    for (int k = 0; k < 20; k++) tick();
    setIn(I_NONE);
    check("sat_stall", 32'(bStallCnt), 32'd15);
    check("sat_flush", 32'(bFlushCnt), 32'd0);

    // Reset asserted while in MD_WAIT.
    setIn(I_MREQ);
    tick();
    tick();
    check("mr_pre_state", 32'(aState), 32'd2);
    reset = 1'b1;
    #1;
    check("mr_state", 32'(aState), 32'd0);
    check("mr_ctl", 32'(aCtl), 32'(C_RST));
    check("mr_cnt", aStallCnt, 32'd0);
    tick();
    check("mr_ctl_hold", 32'(aCtl), 32'(C_RST));
    reset = 1'b0;
    setIn(I_NONE);
    check("mr_release_ctl", 32'(aCtl), 32'(C_DEF));
    tick();
    check("mr_release_state", 32'(aState), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
